// File: rtl/neighbor_table_update.sv
// neighbor_table_update
//   Merges the sender of a received beacon into the shared data-memory tables:
//   neighbour IDs, parallel cluster IDs, known sinks and the two count words.
//   Talks to a single-port 16-bit memory. Addresses are byte addresses and each
//   word occupies 2 bytes. Read data is valid in the cycle after the address is
//   registered. A write happens on each rising edge where wr_en is 1.
//
// Ports
//   clock, nrst      clock, synchronous active-low reset
//   en               re-arm from HOLD (clears done/table_full/sink_added)
//   start            begin one update (sampled in IDLE only)
//   pkt_src_id       sender node ID
//   pkt_cluster_id   sender cluster ID
//   pkt_is_sink      sender advertises itself as a sink
//   data_in          memory read data
//   address          memory byte address
//   wr_en            memory write strobe
//   data_out         memory write data
//   table_full       an append was refused because a table was at capacity
//   sink_added       a new sink was appended during this update
//   done             update complete, held until re-armed
//   drop_count       (only with NBR_UPDATE_DROP_CNT_EN) saturating count of
//                    updates that set table_full; not cleared by en
//
// Optional feature macro: NBR_UPDATE_DROP_CNT_EN
module neighbor_table_update #(
  parameter int unsigned MAX_NEIGHBORS   = 64,
  parameter int unsigned MAX_SINKS       = 32,
  parameter logic [15:0] NBR_ID_BASE     = 16'h48,
  parameter logic [15:0] CLUSTER_ID_BASE = 16'hC8,
  parameter logic [15:0] SINK_BASE       = 16'h8,
  parameter logic [15:0] SINK_CNT_ADDR   = 16'h688,
  parameter logic [15:0] NBR_CNT_ADDR    = 16'h68A
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] pkt_src_id,
  input  logic [15:0] pkt_cluster_id,
  input  logic        pkt_is_sink,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic        wr_en,
  output logic [15:0] data_out,
  output logic        table_full,
  output logic        sink_added,
`ifdef NBR_UPDATE_DROP_CNT_EN
  output logic        done,
  output logic [15:0] drop_count
`else
  output logic        done
`endif
);

  localparam logic [15:0] MAX_NBR_W  = 16'(MAX_NEIGHBORS);
  localparam logic [15:0] MAX_SINK_W = 16'(MAX_SINKS);

  typedef enum logic [3:0] {
    HOLD, IDLE, LD_NCNT, LD_SCNT, N_ID, NEW_NBR, NEW_CID, WR_NCNT,
    SINK_CHK, S_ID, NEW_SINK, WR_SCNT, DONE
  } state_t;

  state_t      state;
  logic [15:0] src, cid;
  logic        is_sink;
  logic [15:0] nc, sc;
  logic [15:0] i, j;

  // Byte offset of a word index; wraps at 16 bits like all address arithmetic.
  function automatic logic [15:0] word_off(input logic [15:0] idx);
    return {idx[14:0], 1'b0};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state      <= HOLD;
      wr_en      <= 1'b0;
      done       <= 1'b0;
      table_full <= 1'b0;
      sink_added <= 1'b0;
      data_out   <= 16'd0;
      address    <= NBR_CNT_ADDR;
      i          <= 16'd0;
      j          <= 16'd0;
`ifdef NBR_UPDATE_DROP_CNT_EN
      drop_count <= 16'd0;
`endif
    end else begin
      case (state)
        HOLD: if (en) begin
          done       <= 1'b0;
          table_full <= 1'b0;
          sink_added <= 1'b0;
          state      <= IDLE;
        end
        IDLE: if (start) begin
          src     <= pkt_src_id;
          cid     <= pkt_cluster_id;
          is_sink <= pkt_is_sink;
          address <= NBR_CNT_ADDR;
          state   <= LD_NCNT;
        end
        LD_NCNT: begin
          nc      <= data_in;
          address <= SINK_CNT_ADDR;
          state   <= LD_SCNT;
        end
        LD_SCNT: begin
          sc <= data_in;
          i  <= 16'd0;
          if (nc == 16'd0) begin
            state <= NEW_NBR;
          end else begin
            address <= NBR_ID_BASE;
            state   <= N_ID;
          end
        end
        // Linear scan, one neighbour entry compared per cycle.
        N_ID: begin
          if (data_in == src) begin
            address  <= CLUSTER_ID_BASE + word_off(i);
            data_out <= cid;
            wr_en    <= 1'b1;
            state    <= SINK_CHK;
          end else begin
            i <= i + 16'd1;
            if (i + 16'd1 == nc) state <= NEW_NBR;
            else address <= NBR_ID_BASE + word_off(i + 16'd1);
          end
        end
        // Count words above capacity are treated as full.
        NEW_NBR: begin
          if (nc >= MAX_NBR_W) begin
            table_full <= 1'b1;
            wr_en      <= 1'b0;
            state      <= SINK_CHK;
          end else begin
            address  <= NBR_ID_BASE + word_off(nc);
            data_out <= src;
            wr_en    <= 1'b1;
            state    <= NEW_CID;
          end
        end
        NEW_CID: begin
          address  <= CLUSTER_ID_BASE + word_off(nc);
          data_out <= cid;
          state    <= WR_NCNT;
        end
        WR_NCNT: begin
          address  <= NBR_CNT_ADDR;
          data_out <= nc + 16'd1;
          state    <= SINK_CHK;
        end
        // The last neighbour-side write (if any) lands on the edge leaving here.
        SINK_CHK: begin
          wr_en <= 1'b0;
          if (!is_sink) begin
            state <= DONE;
          end else if (sc == 16'd0) begin
            state <= NEW_SINK;
          end else begin
            j       <= 16'd0;
            address <= SINK_BASE;
            state   <= S_ID;
          end
        end
        S_ID: begin
          if (data_in == src) begin
            state <= DONE;
          end else begin
            j <= j + 16'd1;
            if (j + 16'd1 == sc) state <= NEW_SINK;
            else address <= SINK_BASE + word_off(j + 16'd1);
          end
        end
        NEW_SINK: begin
          if (sc >= MAX_SINK_W) begin
            table_full <= 1'b1;
            wr_en      <= 1'b0;
            state      <= DONE;
          end else begin
            address  <= SINK_BASE + word_off(sc);
            data_out <= src;
            wr_en    <= 1'b1;
            state    <= WR_SCNT;
          end
        end
        WR_SCNT: begin
          address    <= SINK_CNT_ADDR;
          data_out   <= sc + 16'd1;
          sink_added <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          wr_en <= 1'b0;
          done  <= 1'b1;
`ifdef NBR_UPDATE_DROP_CNT_EN
          // table_full was cleared at re-arm, so this counts once per update.
          if (table_full) drop_count <= sat_inc(drop_count);
`endif
          state <= HOLD;
        end
        default: state <= HOLD;
      endcase
    end
  end

`ifndef NBR_UPDATE_DROP_CNT_EN
  // Saturating helper only used by the optional drop counter.
  logic [15:0] unused_sat;
  assign unused_sat = sat_inc(16'd0);
`endif

endmodule

// File: tb/tb_neighbor_table_update.sv
module tb_neighbor_table_update;

  logic        clock = 1'b0;
  logic        nrst, en, start, pkt_is_sink;
  logic [15:0] pkt_src_id, pkt_cluster_id;
  logic [15:0] data_in, address, data_out;
  logic        wr_en, table_full, sink_added, done;
`ifdef NBR_UPDATE_DROP_CNT_EN
  logic [15:0] drop_count;
  int          exp_drop;
`endif

  always #5 clock = ~clock;

  neighbor_table_update dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .pkt_src_id(pkt_src_id), .pkt_cluster_id(pkt_cluster_id),
    .pkt_is_sink(pkt_is_sink), .data_in(data_in), .address(address),
    .wr_en(wr_en), .data_out(data_out), .table_full(table_full),
    .sink_added(sink_added),
`ifdef NBR_UPDATE_DROP_CNT_EN
    .done(done), .drop_count(drop_count)
`else
    .done(done)
`endif
  );

  // Word-indexed memory; word index = byte address / 2.
  logic [15:0] mem     [0:1023];
  logic [15:0] exp_mem [0:1023];
  int          wr_cnt;
  int          n_vec, n_err;

  assign data_in = mem[address[10:1]];

  always @(posedge clock) begin
    if (wr_en) begin
      mem[address[10:1]] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end
  end

  localparam int W_NBR  = 16'h48 / 2;
  localparam int W_CID  = 16'hC8 / 2;
  localparam int W_SINK = 16'h8 / 2;
  localparam int W_SCNT = 16'h688 / 2;
  localparam int W_NCNT = 16'h68A / 2;

  task automatic clear_mem();
    for (int k = 0; k < 1024; k++) mem[k] = 16'd0;
  endtask

  task automatic snapshot();
    for (int k = 0; k < 1024; k++) exp_mem[k] = mem[k];
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== exp_mem[k]) d++;
    return d;
  endfunction

  // Reference: apply the table-merge rules to exp_mem and predict flags,
  // number of memory writes and start-to-done latency in cycles.
  task automatic model(input logic [15:0] s, input logic [15:0] c, input bit sk,
                       output bit e_full, output bit e_sa, output int e_wr,
                       output int e_lat);
    int nc, sc, hit;
    nc = exp_mem[W_NCNT]; sc = exp_mem[W_SCNT];
    e_full = 0; e_sa = 0; e_wr = 0; e_lat = 3;
    hit = -1;
    for (int k = 0; k < nc; k++) if (hit < 0 && exp_mem[W_NBR + k] == s) hit = k;
    e_lat += (nc == 0) ? 0 : ((hit >= 0) ? hit + 1 : nc);
    if (hit >= 0) begin
      exp_mem[W_CID + hit] = c; e_wr += 1;
    end else begin
      e_lat += 1;
      if (nc >= 64) e_full = 1;
      else begin
        exp_mem[W_NBR + nc] = s; exp_mem[W_CID + nc] = c;
        exp_mem[W_NCNT] = 16'(nc + 1); e_wr += 3; e_lat += 2;
      end
    end
    e_lat += 1;
    if (sk) begin
      hit = -1;
      for (int k = 0; k < sc; k++) if (hit < 0 && exp_mem[W_SINK + k] == s) hit = k;
      e_lat += (sc == 0) ? 0 : ((hit >= 0) ? hit + 1 : sc);
      if (hit < 0) begin
        e_lat += 1;
        if (sc >= 32) e_full = 1;
        else begin
          exp_mem[W_SINK + sc] = s; exp_mem[W_SCNT] = 16'(sc + 1);
          e_wr += 2; e_lat += 1; e_sa = 1;
        end
      end
    end
    e_lat += 1;
  endtask

  task automatic do_update(input logic [15:0] s, input logic [15:0] c, input bit sk,
                           output int lat);
    @(negedge clock); en = 1'b1;
    @(negedge clock); en = 1'b0; wr_cnt = 0;
    start = 1'b1; pkt_src_id = s; pkt_cluster_id = c; pkt_is_sink = sk;
    @(negedge clock); start = 1'b0; lat = 1;
    while (!done && lat < 1000) begin @(negedge clock); lat++; end
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; start = 1'b0;
    pkt_src_id = 16'd0; pkt_cluster_id = 16'd0; pkt_is_sink = 1'b0;
    wr_cnt = 0;
    clear_mem();
    repeat (2) @(negedge clock);
`ifdef NBR_UPDATE_DROP_CNT_EN
    exp_drop = 0;
    n_vec++; if (drop_count !== 16'd0) begin n_err++;
      $display("FAIL reset_drop_count got=%h want=0000", drop_count); end
`endif
    n_vec++; if ({wr_en, done, table_full, sink_added} !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags got=%b want=0000", {wr_en, done, table_full, sink_added}); end
    n_vec++; if (address !== 16'h68A || data_out !== 16'd0) begin n_err++;
      $display("FAIL reset_bus addr=%h dout=%h want 068a/0000", address, data_out); end
    nrst = 1'b1;
    // start without en must be ignored in HOLD
    @(negedge clock); start = 1'b1; @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    n_vec++; if (done !== 1'b0 || wr_cnt !== 0) begin n_err++;
      $display("FAIL hold_ignores_start done=%b writes=%0d want 0/0", done, wr_cnt); end
  endtask

  task automatic test_empty_tables();
    bit ef, es; int ew, el, lat;
    clear_mem(); snapshot();
    model(16'd5, 16'd2, 1'b0, ef, es, ew, el);
    do_update(16'd5, 16'd2, 1'b0, lat);
    n_vec++; if (mem[W_NBR] !== 16'd5 || mem[W_CID] !== 16'd2 || mem[W_NCNT] !== 16'd1) begin
      n_err++; $display("FAIL empty_append nbr=%0d cid=%0d cnt=%0d want 5/2/1",
                        mem[W_NBR], mem[W_CID], mem[W_NCNT]); end
    n_vec++; if (done !== 1'b1 || sink_added !== 1'b0 || table_full !== 1'b0) begin n_err++;
      $display("FAIL empty_flags done=%b sa=%b full=%b want 1/0/0", done, sink_added, table_full); end
    n_vec++; if (lat !== el || wr_cnt !== ew) begin n_err++;
      $display("FAIL empty_timing lat=%0d writes=%0d want %0d/%0d", lat, wr_cnt, el, ew); end
  endtask

  task automatic test_known_nbr();
    bit ef, es; int ew, el, lat;
    clear_mem();
    mem[W_NBR] = 16'd7; mem[W_NBR + 1] = 16'd5; mem[W_NCNT] = 16'd2;
    snapshot();
    model(16'd5, 16'd9, 1'b0, ef, es, ew, el);
    do_update(16'd5, 16'd9, 1'b0, lat);
    n_vec++; if (mem[W_CID + 1] !== 16'd9 || mem[W_NCNT] !== 16'd2 || mem[W_NBR + 2] !== 16'd0) begin
      n_err++; $display("FAIL known_refresh cid=%0d cnt=%0d next=%0d want 9/2/0",
                        mem[W_CID + 1], mem[W_NCNT], mem[W_NBR + 2]); end
    n_vec++; if (wr_cnt !== 1 || lat !== 7) begin n_err++;
      $display("FAIL known_timing writes=%0d lat=%0d want 1/7", wr_cnt, lat); end
  endtask

  task automatic test_new_sink();
    int lat;
    clear_mem();
    do_update(16'd3, 16'd4, 1'b1, lat);
    n_vec++; if (mem[W_SINK] !== 16'd3 || mem[W_SCNT] !== 16'd1 || mem[W_NBR] !== 16'd3) begin
      n_err++; $display("FAIL new_sink sink=%0d scnt=%0d nbr=%0d want 3/1/3",
                        mem[W_SINK], mem[W_SCNT], mem[W_NBR]); end
    n_vec++; if (sink_added !== 1'b1 || wr_cnt !== 5) begin n_err++;
      $display("FAIL new_sink_flags sa=%b writes=%0d want 1/5", sink_added, wr_cnt); end
    // Same sender again: known neighbour and known sink
    do_update(16'd3, 16'd4, 1'b1, lat);
    n_vec++; if (sink_added !== 1'b0 || wr_cnt !== 1 || mem[W_SCNT] !== 16'd1) begin n_err++;
      $display("FAIL known_sink sa=%b writes=%0d scnt=%0d want 0/1/1", sink_added, wr_cnt, mem[W_SCNT]); end
  endtask

  task automatic test_nbr_full();
    int lat;
    clear_mem();
    for (int k = 0; k < 64; k++) mem[W_NBR + k] = 16'(100 + k);
    mem[W_NCNT] = 16'd64;
    do_update(16'd7, 16'd1, 1'b0, lat);
    n_vec++; if (table_full !== 1'b1 || wr_cnt !== 0 || done !== 1'b1) begin n_err++;
      $display("FAIL nbr_full full=%b writes=%0d done=%b want 1/0/1", table_full, wr_cnt, done); end
`ifdef NBR_UPDATE_DROP_CNT_EN
    exp_drop++;
    n_vec++; if (drop_count !== 16'(exp_drop)) begin n_err++;
      $display("FAIL nbr_full_drop got=%0d want=%0d", drop_count, exp_drop); end
`endif
  endtask

  task automatic test_reset_mid_op();
    clear_mem();
    @(negedge clock); en = 1'b1; @(negedge clock); en = 1'b0; wr_cnt = 0;
    start = 1'b1; pkt_src_id = 16'd5; pkt_cluster_id = 16'd2; pkt_is_sink = 1'b0;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++; if (wr_en !== 1'b1) begin n_err++;
      $display("FAIL midop_in_new_cid wr_en=%b want 1", wr_en); end
    nrst = 1'b0;
    @(negedge clock);
    n_vec++; if (wr_en !== 1'b0 || done !== 1'b0 || address !== 16'h68A) begin n_err++;
      $display("FAIL midop_abort wr_en=%b done=%b addr=%h want 0/0/068a", wr_en, done, address); end
    nrst = 1'b1;
`ifdef NBR_UPDATE_DROP_CNT_EN
    exp_drop = 0;
`endif
    repeat (12) @(negedge clock);
    n_vec++; if (mem[W_NCNT] !== 16'd0 || done !== 1'b0 || wr_cnt !== 1) begin n_err++;
      $display("FAIL midop_hold ncnt=%0d done=%b writes=%0d want 0/0/1", mem[W_NCNT], done, wr_cnt); end
  endtask

  task automatic test_random();
    bit ef, es; int ew, el, lat, nc, sc;
    logic [15:0] s, c; bit sk;
    for (int it = 0; it < 40; it++) begin
      clear_mem();
      nc = ($urandom_range(0, 5) == 0) ? 64 : $urandom_range(0, 66);
      sc = ($urandom_range(0, 5) == 0) ? 32 : $urandom_range(0, 34);
      for (int k = 0; k < nc; k++) begin
        mem[W_NBR + k] = 16'($urandom_range(1, 24)); mem[W_CID + k] = 16'($urandom);
      end
      for (int k = 0; k < sc; k++) mem[W_SINK + k] = 16'($urandom_range(1, 24));
      mem[W_NCNT] = 16'(nc); mem[W_SCNT] = 16'(sc);
      s = 16'($urandom_range(1, 24)); c = 16'($urandom); sk = 1'($urandom);
      snapshot();
      model(s, c, sk, ef, es, ew, el);
      do_update(s, c, sk, lat);
      n_vec++; if (lat !== el) begin n_err++;
        $display("FAIL rnd%0d_latency got=%0d want=%0d", it, lat, el); end
      n_vec++; if ({done, table_full, sink_added} !== {1'b1, ef, es}) begin n_err++;
        $display("FAIL rnd%0d_flags got=%b want=%b", it, {done, table_full, sink_added}, {1'b1, ef, es}); end
      n_vec++; if (wr_cnt !== ew) begin n_err++;
        $display("FAIL rnd%0d_writes got=%0d want=%0d", it, wr_cnt, ew); end
      n_vec++; if (mem_diffs() !== 0) begin n_err++;
        $display("FAIL rnd%0d_memory differing_words=%0d want=0", it, mem_diffs()); end
`ifdef NBR_UPDATE_DROP_CNT_EN
      if (ef) exp_drop++;
      n_vec++; if (drop_count !== 16'(exp_drop)) begin n_err++;
        $display("FAIL rnd%0d_drop got=%0d want=%0d", it, drop_count, exp_drop); end
`endif
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_empty_tables();
    test_known_nbr();
    test_new_sink();
    test_nbr_full();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neighbor_table_update.md
Name: neighbor_table_update

Overview:
- Upstream stage of the neighbour-sink/cluster aggregation check.
- On each received beacon it merges the sender into the shared data-memory tables: neighbour IDs, cluster IDs, known sinks, and both count words.
- The aggregation check later scans these tables.
- Uses the same single-port 16-bit memory bus: byte addresses, one word per 2 bytes, read data valid the cycle after the address is driven.

Parameters:
- MAX_NEIGHBORS, 64, neighbour table capacity in words.
- MAX_SINKS, 32, known-sink table capacity in words.
- NBR_ID_BASE, 16'h48, neighbour ID table base address.
- CLUSTER_ID_BASE, 16'hC8, cluster ID table base address (parallel to the neighbour ID table).
- SINK_BASE, 16'h8, known-sink table base address.
- SINK_CNT_ADDR, 16'h688, knownSinkCount word address.
- NBR_CNT_ADDR, 16'h68A, neighborCount word address.

Ports:
- clock  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- en  in  1  re-arm from HOLD
- start  in  1  begin one update; packet fields sampled this cycle
- pkt_src_id  in  16  sender node ID
- pkt_cluster_id  in  16  sender cluster ID
- pkt_is_sink  in  1  sender advertises itself as sink
- data_in  in  16  memory read data
- address  out  16  memory byte address
- wr_en  out  1  memory write strobe; write occurs at the rising edge where wr_en=1
- data_out  out  16  memory write data
- table_full  out  1  an append was refused due to capacity
- sink_added  out  1  a new sink was appended this update
- done  out  1  update complete; held until re-armed

Behaviour:
- Reset (nrst=0 at a clock edge): wr_en=0, done=0, table_full=0, sink_added=0, data_out=0, address=NBR_CNT_ADDR, i=j=0, state=HOLD.
- Reset mid-operation aborts immediately; no further writes are issued.
- HOLD: when en=1, clear done/table_full/sink_added and go to IDLE. en is ignored in every other state.
- IDLE: when start=1, latch src, cid, is_sink; address=NBR_CNT_ADDR; go to LD_NCNT. start is ignored outside IDLE.
- LD_NCNT: nc=data_in; address=SINK_CNT_ADDR; go to LD_SCNT.
- LD_SCNT: sc=data_in; i=0.
  - nc=0: go to NEW_NBR.
  - otherwise: address=NBR_ID_BASE; go to N_ID.
- N_ID (one entry per cycle):
  - data_in==src: address=CLUSTER_ID_BASE+2i, data_out=cid, wr_en=1 (cluster ID refresh); go to SINK_CHK.
  - otherwise: i=i+1. If i==nc go to NEW_NBR; else address=NBR_ID_BASE+2i.
- NEW_NBR:
  - nc>=MAX_NEIGHBORS: table_full=1, no write; go to SINK_CHK.
  - otherwise: write src to NBR_ID_BASE+2nc; go to NEW_CID.
- NEW_CID: write cid to CLUSTER_ID_BASE+2nc; go to WR_NCNT.
- WR_NCNT: write nc+1 to NBR_CNT_ADDR; go to SINK_CHK.
- Consecutive write states hold wr_en=1, one write per cycle.
- SINK_CHK: wr_en=0.
  - is_sink=0: go to DONE.
  - sc=0: go to NEW_SINK.
  - otherwise: j=0, address=SINK_BASE; go to S_ID.
- S_ID:
  - data_in==src: go to DONE.
  - otherwise: j=j+1. If j==sc go to NEW_SINK; else address=SINK_BASE+2j.
- NEW_SINK:
  - sc>=MAX_SINKS: table_full=1; go to DONE.
  - otherwise: write src to SINK_BASE+2sc; go to WR_SCNT.
- WR_SCNT: write sc+1 to SINK_CNT_ADDR; sink_added=1; go to DONE.
- DONE: wr_en=0, done=1; go to HOLD.
- Address arithmetic is 16-bit, wrapping. Count words above capacity are treated as full.
- Latency, known neighbour and non-sink: 3 + (match index+1) + 2 cycles from start to done.

Optional Feature:
- Macro: NBR_UPDATE_DROP_CNT_EN.
- Defined:
  - Adds output drop_count[15:0], reset 0.
  - Increments (saturating at 16'hFFFF) once per update in which table_full was set.
  - Not cleared by en.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Empty tables (nc=0, sc=0), src=5, cid=2, is_sink=0 -> writes [0x48]=5, [0xC8]=2, [0x68A]=1; sink_added=0; done=1.
- Table {0x48:7, 0x4A:5}, nc=2, src=5, cid=9 -> single write [0xCA]=9; count unchanged; no neighbour append.
- Empty tables, src=3, is_sink=1 -> neighbour appended; then [0x8]=3, [0x688]=1; sink_added=1.
- Sink 3 already at [0x8], sc=1, src=3 known neighbour, is_sink=1 -> no sink write; sink_added=0.
- nc=64, unknown src, not sink -> table_full=1; zero writes; done=1 (drop_count=1 with macro).
- nrst low during NEW_CID -> wr_en=0 the next cycle; [0x68A] never written; HOLD until en.
